// File: rtl/emmc_pkg.sv
// Shared types and constants for the eMMC card-side CMD responder.
package emmc_pkg;

  localparam int FRAME_BITS = 48;
  localparam int CRC_SPAN = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CRC_LAST_BIT = 6'(CRC_SPAN - 1);

  // Offsets inside the 39-bit captured header (direction, index, argument)
  localparam int RX_DIR_POS = 38;
  localparam int RX_IDX_LSB = 32;
  localparam int RX_ARG_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_NCR       = 3'd3,
    ST_TX        = 3'd4,
    ST_TURN      = 3'd5
  } emmc_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/emmc_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), shared by the receive and transmit paths.
module emmc_crc7
  import emmc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  // CRC register: clear has priority over accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 7'h00;
    end else if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/emmc_cmd_responder.sv
// Card-side eMMC CMD line endpoint: receives host commands, returns R1 responses.
// Optional build macro EMMC_CRC_CHECK_EN enables CRC7 checking of received frames.
module emmc_cmd_responder
  import emmc_pkg::*;
#(
  parameter int NCR_CYCLES   = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  output logic        frame_err,
  output logic        resp_ready,
  input  logic        resp_valid,
  input  logic        resp_none,
  input  logic [5:0]  resp_index,
  input  logic [31:0] resp_status,
  output logic        busy
);

  localparam logic [9:0] WAIT_LAST = 10'(WAIT_TIMEOUT - 1);
  localparam logic [6:0] NCR_LAST  = 7'(NCR_CYCLES - 1);

  emmc_state_e state_r, state_nx_s;
  logic [5:0]  bit_cnt_r;
  logic [9:0]  wait_cnt_r;
  logic [6:0]  ncr_cnt_r;
  logic [38:0] rx_sr_r;
  logic [39:0] tx_sr_r;
  logic [6:0]  crc_s;
  logic        crc_clr_s, crc_en_s, crc_bit_s, crc_sel_s, tx_bit_s;
  logic        crc_ok_s, frame_good_s, rx_last_s;

  emmc_crc7 u_crc7 (
    .clk    (mclk),
    .rst    (rst),
    .clr    (crc_clr_s),
    .en     (crc_en_s),
    .bit_in (crc_bit_s),
    .crc    (crc_s)
  );

  // CRC bits 40..46 of a frame map onto crc_s[6..0]
  assign crc_sel_s = crc_s[3'(6'd46 - bit_cnt_r)];
  assign rx_last_s = (state_r == ST_RX) && (bit_cnt_r == LAST_BIT);

`ifdef EMMC_CRC_CHECK_EN
  logic crc_err_r;

  // Accumulate any received CRC bit that disagrees with the running CRC
  always_ff @(posedge mclk) begin
    if (rst) begin
      crc_err_r <= 1'b0;
    end else if (state_r != ST_RX) begin
      crc_err_r <= 1'b0;
    end else if ((bit_cnt_r > CRC_LAST_BIT) && (bit_cnt_r < LAST_BIT) && (cmd_i != crc_sel_s)) begin
      crc_err_r <= 1'b1;
    end
  end

  assign crc_ok_s = ~crc_err_r;
`else
  assign crc_ok_s = 1'b1;
`endif

  assign frame_good_s = rx_sr_r[RX_DIR_POS] & cmd_i & crc_ok_s;
  assign resp_ready   = (state_r == ST_WAIT_RESP);
  assign busy         = (state_r != ST_IDLE);

  // State register
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_i) state_nx_s = ST_RX;
        else        state_nx_s = ST_IDLE;
      end
      ST_RX: begin
        if (rx_last_s) state_nx_s = frame_good_s ? ST_WAIT_RESP : ST_IDLE;
        else           state_nx_s = ST_RX;
      end
      ST_WAIT_RESP: begin
        if (resp_valid)                   state_nx_s = resp_none ? ST_IDLE : ST_NCR;
        else if (!cmd_i)                  state_nx_s = ST_RX;
        else if (wait_cnt_r == WAIT_LAST) state_nx_s = ST_IDLE;
        else                              state_nx_s = ST_WAIT_RESP;
      end
      ST_NCR: begin
        if (ncr_cnt_r == NCR_LAST) state_nx_s = ST_TX;
        else                       state_nx_s = ST_NCR;
      end
      ST_TX: begin
        if (bit_cnt_r == LAST_BIT) state_nx_s = ST_TURN;
        else                       state_nx_s = ST_TX;
      end
      ST_TURN: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // CRC control and transmit bit selection
  always_comb begin
    crc_clr_s = 1'b0;
    crc_en_s  = 1'b0;
    crc_bit_s = (state_r == ST_TX) ? tx_sr_r[39] : cmd_i;
    case (state_r)
      ST_IDLE:      crc_clr_s = 1'b1;
      ST_WAIT_RESP: crc_clr_s = 1'b1;
      ST_RX:        crc_en_s  = (bit_cnt_r <= CRC_LAST_BIT);
      ST_TX:        crc_en_s  = (bit_cnt_r <= CRC_LAST_BIT);
      default:      crc_clr_s = 1'b0;
    endcase

    if (bit_cnt_r <= CRC_LAST_BIT) tx_bit_s = tx_sr_r[39];
    else if (bit_cnt_r < LAST_BIT) tx_bit_s = crc_sel_s;
    else                           tx_bit_s = 1'b1;
  end

  // Datapath: shift registers, counters and registered outputs
  always_ff @(posedge mclk) begin
    if (rst) begin
      cmd_o        <= 1'b1;
      cmd_oe       <= 1'b0;
      cmd_valid    <= 1'b0;
      frame_err    <= 1'b0;
      cmd_index    <= 6'd0;
      cmd_argument <= 32'd0;
      bit_cnt_r    <= 6'd0;
      wait_cnt_r   <= 10'd0;
      ncr_cnt_r    <= 7'd0;
      rx_sr_r      <= 39'd0;
      tx_sr_r      <= 40'd0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_oe    <= 1'b0;
      cmd_o     <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r  <= 6'd1;
          wait_cnt_r <= 10'd0;
        end
        ST_RX: begin
          if (bit_cnt_r <= CRC_LAST_BIT) rx_sr_r <= {rx_sr_r[37:0], cmd_i};
          if (rx_last_s) begin
            wait_cnt_r <= 10'd0;
            if (frame_good_s) begin
              cmd_valid    <= 1'b1;
              cmd_index    <= rx_sr_r[RX_IDX_LSB +: 6];
              cmd_argument <= rx_sr_r[RX_ARG_LSB +: 32];
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end
        end
        ST_WAIT_RESP: begin
          bit_cnt_r <= 6'd1;
          ncr_cnt_r <= 7'd0;
          if (wait_cnt_r != WAIT_LAST) wait_cnt_r <= wait_cnt_r + 10'd1;
          if (resp_valid && !resp_none) tx_sr_r <= {2'b00, resp_index, resp_status};
        end
        ST_NCR: begin
          bit_cnt_r <= 6'd0;
          if (ncr_cnt_r != NCR_LAST) ncr_cnt_r <= ncr_cnt_r + 7'd1;
        end
        ST_TX: begin
          cmd_oe <= 1'b1;
          cmd_o  <= tx_bit_s;
          if (bit_cnt_r <= CRC_LAST_BIT) tx_sr_r <= {tx_sr_r[38:0], 1'b0};
          if (bit_cnt_r != LAST_BIT) bit_cnt_r <= bit_cnt_r + 6'd1;
        end
        ST_TURN: begin
          cmd_oe <= 1'b1;
          cmd_o  <= 1'b1;
        end
        default: begin
          bit_cnt_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/emmc_cmd_responder.md
Name: emmc_cmd_responder

Overview:
Device-side endpoint of the eMMC CMD line: the card end of the host socket's command path.
- Samples 48-bit host command frames from the shared CMD wire and checks framing and CRC7.
- Hands index/argument to card logic.
- After the card logic supplies status, waits NCR cycles and drives a 48-bit R1-format response back on the same open-drain/pull-up line.
- Sits between the CMD pad tri-state and the card's command decoder.

Parameters:
NCR_CYCLES, 2, idle cycles between response handshake and response start bit (legal 2..64)
WAIT_TIMEOUT, 64, max cycles in WAIT_RESP before abandoning the response (legal 1..1023)

Ports:
mclk  input  1  card clock; all logic on rising edge
rst  input  1  synchronous active-high reset
cmd_i  input  1  sampled CMD line (reads 1 when idle via pull-up)
cmd_o  output  1  value driven onto CMD when cmd_oe=1
cmd_oe  output  1  CMD pad output enable
cmd_valid  output  1  one-cycle pulse: good command captured
cmd_index  output  6  index of last good command, held until next good one
cmd_argument  output  32  argument of last good command, held
frame_err  output  1  one-cycle pulse: bad transmission bit, end bit or CRC
resp_ready  output  1  high only in WAIT_RESP
resp_valid  input  1  card logic presents response
resp_none  input  1  with resp_valid: command needs no response
resp_index  input  6  response index field
resp_status  input  32  R1 card status
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: cmd_o=1, cmd_oe=0, cmd_valid=0, frame_err=0, resp_ready=0, busy=0, cmd_index=0, cmd_argument=0, state IDLE, counters 0. Reset mid-TX releases the line on the next edge.
- Frame layout, MSB first: start 0, direction bit (host=1, card=0), index[5:0], payload[31:0], crc7[6:0], end 1.
- CRC7: poly x^7+x^3+1, init 0, over the first 40 bits.
- IDLE: cmd_i=0 sampled → RX, bit counter=1.
- RX: shift one bit per cycle through bit 47. Then:
  - good (dir=1, end=1, CRC match) → cmd_valid pulse and index/argument update one cycle after the end bit is sampled; state → WAIT_RESP.
  - bad → frame_err pulse, outputs unchanged; state → IDLE.
- WAIT_RESP:
  - resp_valid & resp_none → IDLE.
  - resp_valid alone → latch index/status, → NCR.
  - cmd_i=0 sampled (host restarted) → abandon, → RX with counter=1.
  - WAIT_TIMEOUT cycles without resp_valid → IDLE.
  - resp_valid outside WAIT_RESP is ignored.
- NCR: cmd_oe=0 for exactly NCR_CYCLES cycles, then → TX.
- TX: 48 bits, cmd_oe=1, dir bit=0, CRC7 computed on the fly. Start bit appears on cmd_o at the edge NCR_CYCLES+1 cycles after the handshake edge.
- Turnaround: after the end bit, one extra cycle cmd_oe=1/cmd_o=1 drives the line high, then cmd_oe=0, → IDLE. cmd_i is ignored during NCR/TX/turnaround.
- Counters saturate cleanly; no wrap into a false start.

Optional Feature:
EMMC_CRC_CHECK_EN
- Defined: RX CRC7 is compared; a mismatch gives frame_err.
- Undefined: received CRC field is ignored, and only dir/end bit errors give frame_err. TX CRC generation is always present.

Decomposition:
- Package emmc_pkg:
  - FRAME_BITS=48, CRC7_POLY=7'h09
  - state enum {IDLE, RX, WAIT_RESP, NCR, TX, TURN}
  - field offset constants
- Sub-module emmc_crc7: serial CRC7 with clear/enable/bit inputs, 7-bit output. One instance, shared by RX and TX since they never overlap.

Test Plan:
- Host sends CMD0 arg 0 (0x40_00000000_95), resp_valid&resp_none next cycle → cmd_valid pulse, cmd_index=0, no drive, busy low within 2 cycles.
- Host sends CMD17 arg 0 (0x51_00000000_55); respond index 17, status 0x00000900 → after NCR_CYCLES=2 cycles, CMD carries 0x11_00000900_67 MSB first, then one driven-high cycle, then release.
- CMD17 with CRC byte 0x57 → frame_err pulse, cmd_index unchanged, back to IDLE. With macro off → cmd_valid instead.
- Good command, no resp_valid → IDLE after exactly 64 cycles, cmd_oe never asserted.
- Host start bit during WAIT_RESP, followed by valid CMD1 arg 0xF0F0F0F0 → first command abandoned, cmd_valid for index 1 with argument 0xF0F0F0F0.
- rst asserted at TX bit 20 → next edge cmd_oe=0, cmd_o=1, state IDLE; a following command is received normally.
